shift_reg2_ctrl: RTL and testbench

Command sequencer for the 8-bit `shift_reg2` register: it accepts one shift command at a time over a valid/ready handshake. It optionally parallel-loads the register, then drives `enable` and `shift_direction` for exactly the requested number of clock cycles. It then returns the final register contents over a valid/ready response channel. It sits between the control fabric and a single `shift_reg2` instance, and is the only driver of that instance's `enable`, `shift_direction` and `data_in`.

---
 rtl/shift_reg2_ctrl.sv | 121 ++++++++++++
 tb/tb_shift_reg2_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg2_ctrl.sv
// Command sequencer for a shift_reg2 instance: optional parallel load, N shift cycles,
// then a held response carrying the final register value.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high
// S_LOAD  | one enable cycle with LOAD_CODE, data_in = captured data
// S_SHIFT | enable cycles with captured op, rem counts down to 1
// S_RESP  | register held, response presented until rsp_ready
module shift_reg2_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CNT_W     = 4,
   parameter logic [2:0]  LOAD_CODE = 3'b011
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_load,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   output logic             sr_enable,
   output logic [2:0]       sr_shift_direction,
   output logic [WIDTH-1:0] sr_data_in,
   input  logic [WIDTH-1:0] sr_data_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [CNT_W-1:0] rsp_count,
   output logic             rsp_aborted,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_RESP} state_t;

   state_t           state;
   logic [2:0]       op;
   logic [WIDTH-1:0] data;
   logic [CNT_W-1:0] rem;
   logic [CNT_W-1:0] done_cnt;
   logic             aborted;

   // The load flag is carried by the LOAD state itself, so no separate register is kept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         op       <= 3'b000;
         data     <= '0;
         rem      <= '0;
         done_cnt <= '0;
         aborted  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op       <= cmd_op;
                  data     <= cmd_data;
                  rem      <= cmd_count;
                  done_cnt <= '0;
                  aborted  <= 1'b0;
                  if (cmd_load)
                     state <= S_LOAD;
                  else if (cmd_count != '0)
                     state <= S_SHIFT;
                  else
                     state <= S_RESP;
               end
            end
            S_LOAD: begin
               if (abort) begin
                  aborted <= 1'b1;
                  state   <= S_RESP;
               end else if (rem != '0) begin
                  state <= S_SHIFT;
               end else begin
                  state <= S_RESP;
               end
            end
            S_SHIFT: begin
               if (abort) begin
                  aborted <= 1'b1;
                  state   <= S_RESP;
               end else begin
                  rem      <= rem - CNT_W'(1);
                  done_cnt <= done_cnt + CNT_W'(1);
                  if (rem == CNT_W'(1))
                     state <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // abort gates the enable in the same cycle so the aborted edge never reaches the register
   assign sr_enable  = ((state == S_LOAD) || (state == S_SHIFT)) && !abort;
   assign sr_data_in = data;

   always_comb begin
      sr_shift_direction = 3'b000;
      case (state)
         S_LOAD:  sr_shift_direction = LOAD_CODE;
         S_SHIFT: sr_shift_direction = op;
         default: sr_shift_direction = 3'b000;
      endcase
   end

   assign cmd_ready   = (state == S_IDLE);
   assign busy        = (state != S_IDLE);
   assign rsp_valid   = (state == S_RESP);
   assign rsp_data    = sr_data_out;
   assign rsp_count   = rsp_valid ? done_cnt : '0;
   assign rsp_aborted = rsp_valid & aborted;

endmodule

// File: tb/tb_shift_reg2_ctrl.sv
// Bench for shift_reg2_ctrl: a register stand-in driven by the DUT, a schedule-based
// reference model, per-cycle comparison on the falling edge and directed/random commands.
module tb_shift_reg2_ctrl;

   localparam int         WIDTH     = 8;
   localparam int         CNT_W     = 4;
   localparam logic [2:0] LOAD_CODE = 3'b011;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = 3'b000;
   logic [CNT_W-1:0] cmd_count = '0;
   logic             cmd_load = 1'b0;
   logic [WIDTH-1:0] cmd_data = '0;
   logic             abort = 1'b0;
   logic             sr_enable;
   logic [2:0]       sr_shift_direction;
   logic [WIDTH-1:0] sr_data_in;
   logic [WIDTH-1:0] sr_data_out;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_data;
   logic [CNT_W-1:0] rsp_count;
   logic             rsp_aborted;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   shift_reg2_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LOAD_CODE(LOAD_CODE)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_count(cmd_count), .cmd_load(cmd_load), .cmd_data(cmd_data),
      .abort(abort),
      .sr_enable(sr_enable), .sr_shift_direction(sr_shift_direction),
      .sr_data_in(sr_data_in), .sr_data_out(sr_data_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_count(rsp_count), .rsp_aborted(rsp_aborted), .busy(busy)
   );

   // shift_reg2 behaviour: 001 shl, 010 shr, 011 load, 100 rol, 101 ror, others hold
   function automatic logic [7:0] reg_next(input logic [7:0] q, input logic [2:0] dir,
                                           input logic [7:0] din);
      case (dir)
         3'b001:  return {q[6:0], 1'b0};
         3'b010:  return {1'b0, q[7:1]};
         3'b011:  return din;
         3'b100:  return {q[6:0], q[7]};
         3'b101:  return {q[0], q[7:1]};
         default: return q;
      endcase
   endfunction

   logic [7:0] sr_q = 8'h00;
   assign sr_data_out = sr_q;
   always @(posedge clk) if (sr_enable === 1'b1) sr_q <= reg_next(sr_q, sr_shift_direction, sr_data_in);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a command becomes a list of enable cycles still owed.
   typedef struct packed {logic is_load; logic [2:0] code;} act_t;
   act_t       sched[$];
   int         m_mode = 0;   // 0 idle, 1 working through sched, 2 responding
   logic [7:0] m_data = 8'h00;
   logic [7:0] m_reg  = 8'h00;
   int         m_done = 0;
   bit         m_ab   = 1'b0;

   task automatic model_step();
      act_t a;
      if (!reset) begin
         m_mode = 0; sched.delete(); m_done = 0; m_ab = 1'b0; m_data = 8'h00;
      end else begin
         case (m_mode)
            0: if (cmd_valid) begin
               m_data = cmd_data; m_done = 0; m_ab = 1'b0; sched.delete();
               if (cmd_load) begin a.is_load = 1'b1; a.code = LOAD_CODE; sched.push_back(a); end
               for (int i = 0; i < int'(cmd_count); i++) begin
                  a.is_load = 1'b0; a.code = cmd_op; sched.push_back(a);
               end
               m_mode = (sched.size() > 0) ? 1 : 2;
            end
            1: if (abort) begin
               m_ab = 1'b1; sched.delete(); m_mode = 2;
            end else begin
               a = sched.pop_front();
               m_reg = reg_next(m_reg, a.code, m_data);
               if (!a.is_load) m_done++;
               if (sched.size() == 0) m_mode = 2;
            end
            default: if (rsp_ready) m_mode = 0;
         endcase
      end
   endtask

   task automatic compare();
      logic       exp_en;
      logic [2:0] exp_dir;
      exp_en  = (m_mode == 1) && !abort;
      exp_dir = (m_mode == 1) ? sched[0].code : 3'b000;
      chk("cmd_ready", cmd_ready, m_mode == 0);
      chk("busy", busy, m_mode != 0);
      chk("sr_enable", sr_enable, exp_en);
      chk("sr_shift_direction", sr_shift_direction, exp_dir);
      chk("sr_data_in", sr_data_in, m_data);
      chk("rsp_valid", rsp_valid, m_mode == 2);
      chk("rsp_data", rsp_data, m_reg);
      chk("rsp_count", rsp_count, (m_mode == 2) ? m_done : 0);
      chk("rsp_aborted", rsp_aborted, (m_mode == 2) && m_ab);
   endtask

   initial forever begin @(posedge clk or negedge reset); model_step(); end
   initial forever begin @(negedge clk); compare(); end

   logic [7:0] r_data;
   logic [3:0] r_count;
   logic       r_ab;
   int         r_lat, r_wait;

   // Called and returns 1 time unit after a rising edge.
   task automatic run_cmd(input bit ld, input logic [7:0] d, input logic [2:0] op,
                          input int cnt, input int ab_cyc, input int bp);
      int n;
      int lat;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (cmd_ready !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL cmd_accept_timeout: cmd_ready %b expected 1", cmd_ready);
      end
      r_wait = n;
      cmd_valid = 1'b1; cmd_load = ld; cmd_data = d; cmd_op = op; cmd_count = CNT_W'(cnt);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 0;
      if (ab_cyc >= 0) begin
         repeat (ab_cyc) begin @(posedge clk); #1; lat++; end
         abort = 1'b1;
         #1 chk("abort_enable_low", sr_enable, 1'b0);
         @(posedge clk); #1;
         abort = 1'b0;
         lat++;
      end
      while (rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      chk("rsp_latency", lat, (ab_cyc >= 0) ? ab_cyc + 1 : int'(ld) + cnt);
      r_lat = lat; r_data = rsp_data; r_count = rsp_count; r_ab = rsp_aborted;
      repeat (bp) begin
         @(posedge clk); #1;
         chk("bp_rsp_valid", rsp_valid, 1'b1);
         chk("bp_rsp_data", rsp_data, r_data);
         chk("bp_rsp_count", rsp_count, r_count);
         chk("bp_rsp_aborted", rsp_aborted, r_ab);
         chk("bp_cmd_ready", cmd_ready, 1'b0);
         chk("bp_sr_enable", sr_enable, 1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("idle_after_rsp", busy, 1'b0);
   endtask

   initial begin
      bit ld;
      int cnt, ab, bp;
      #1 reset = 1'b0;
      #1 chk("reset_cmd_ready", cmd_ready, 1'b1);
      chk("reset_sr_enable", sr_enable, 1'b0);
      chk("reset_sr_data_in", sr_data_in, 8'h00);
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk); #1;

      run_cmd(1'b1, 8'hA5, 3'b000, 0, -1, 0);
      chk("load_only_data", r_data, 8'hA5);
      chk("load_only_count", r_count, 4'd0);
      chk("load_only_aborted", r_ab, 1'b0);

      run_cmd(1'b1, 8'h81, 3'b001, 3, -1, 0);
      chk("load_shift_data", r_data, 8'h08);
      chk("load_shift_count", r_count, 4'd3);

      run_cmd(1'b0, 8'h00, 3'b100, 10, 3, 0);
      chk("abort_data", r_data, 8'h40);
      chk("abort_count", r_count, 4'd3);
      chk("abort_flag", r_ab, 1'b1);

      run_cmd(1'b0, 8'h00, 3'b010, 2, -1, 20);
      chk("bp_data", r_data, 8'h10);
      chk("bp_count", r_count, 4'd2);

      run_cmd(1'b0, 8'hFF, 3'b001, 0, -1, 0);
      chk("next_cmd_wait", r_wait, 0);
      chk("zero_data", r_data, 8'h10);
      chk("zero_count", r_count, 4'd0);
      chk("zero_latency", r_lat, 0);

      run_cmd(1'b0, 8'h00, 3'b101, 15, -1, 0);
      chk("max_data", r_data, 8'h20);
      chk("max_count", r_count, 4'd15);

      cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'b001; cmd_count = 4'd5;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_enable", sr_enable, 1'b1);
      reset = 1'b0;
      #1 chk("midreset_enable", sr_enable, 1'b0);
      chk("midreset_rsp_valid", rsp_valid, 1'b0);
      chk("midreset_cmd_ready", cmd_ready, 1'b1);
      @(negedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_cmd_ready", cmd_ready, 1'b1);
      run_cmd(1'b0, 8'h00, 3'b101, 1, -1, 0);
      chk("post_reset_count", r_count, 4'd1);

      for (int k = 0; k < 40; k++) begin
         ld  = 1'($urandom_range(0, 1));
         cnt = int'($urandom_range(0, 15));
         bp  = int'($urandom_range(0, 3));
         ab  = -1;
         if ((int'(ld) + cnt > 0) && ($urandom_range(0, 3) == 0))
            ab = int'($urandom_range(0, int'(ld) + cnt - 1));
         run_cmd(ld, 8'($urandom), 3'($urandom), cnt, ab, bp);
      end

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
